// File: rtl/qsys_pio_pkg.sv
// Shared register offsets, edge-mode constants and edge helper for the button PIO.
package qsys_pio_pkg;

  typedef enum logic [1:0] {
    PIO_ADDR_DATA = 2'd0,
    PIO_ADDR_RSVD = 2'd1,
    PIO_ADDR_MASK = 2'd2,
    PIO_ADDR_EDGE = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic logic edge_hit(input int mode, input logic cur, input logic prev);
    case (mode)
      EDGE_FALL: return ~cur & prev;
      EDGE_ANY:  return cur ^ prev;
      default:   return cur & ~prev;
    endcase
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// One PIO input channel: two-flop synchroniser plus optional debouncer.
// The debouncer is built only when QSYS_PIO_DEBOUNCE_EN is defined.
module pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic deb_o
);

  logic [1:0] sync_q;
  logic       sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], din_i};
  end

  assign sync = sync_q[1];

`ifdef QSYS_PIO_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  // Any return to the current debounced level restarts the stability count.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = sync;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb_o = deb_q;
`else
  localparam int UNUSED_CYCLES = DEBOUNCE_CYCLES;

  assign deb_o = sync;
`endif

endmodule

// File: rtl/qsys_button_pio.sv
// Avalon-MM input PIO: per-channel sync/debounce, edge capture (W1C), irq mask.
// Debounce is enabled by defining QSYS_PIO_DEBOUNCE_EN.
module qsys_button_pio
  import qsys_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_dly_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rdata_q, rdata_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .din_i(in_port[g]),
      .deb_o(deb[g])
    );
  end

  assign wr_en        = chipselect & write;
  assign unused_wdata = ^writedata;

  // A new edge in the same cycle as a W1C of that bit keeps the bit set.
  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && address == PIO_ADDR_MASK) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == PIO_ADDR_EDGE) clr = writedata[WIDTH-1:0];
    cap_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cap_d[i] = (cap_q[i] & ~clr[i]) | edge_hit(EDGE_MODE, deb[i], deb_dly_q[i]);
    end
  end

  always_comb begin
    rdata_d = '0;
    case (pio_addr_e'(address))
      PIO_ADDR_DATA: rdata_d[WIDTH-1:0] = deb;
      PIO_ADDR_MASK: rdata_d[WIDTH-1:0] = mask_q;
      PIO_ADDR_EDGE: rdata_d[WIDTH-1:0] = cap_q;
      default:       rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_dly_q <= '0;
      mask_q    <= '0;
      cap_q     <= '0;
      rdata_q   <= '0;
    end else begin
      deb_dly_q <= deb;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      rdata_q   <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_qsys_button_pio.sv
// Scoreboard bench for qsys_button_pio: rising-edge DUT plus an any-edge DUT on one bus.
module tb_qsys_button_pio;

`ifdef QSYS_PIO_DEBOUNCE_EN
  localparam int D = 16;
`else
  localparam int D = 0;
`endif
  localparam int W = D + 4;

  localparam int K_RD0  = 0;
  localparam int K_IRQ0 = 1;
  localparam int K_RD1  = 2;
  localparam int K_IRQ1 = 3;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  logic        chk_req = 1'b0;
  logic        chk_vld = 1'b0;
  chk_t        sb[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  qsys_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_MODE(0)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  qsys_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_MODE(2)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1)
  );

  always @(posedge clk) chk_vld <= chk_req;

  always @(negedge clk) begin
    if (chk_vld) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: got check strobe required queued entry");
      end else begin
        chk_t        e;
        logic [31:0] act;
        e = sb.pop_front();
        case (e.kind)
          K_RD0:   act = rd0;
          K_IRQ0:  act = {31'd0, irq0};
          K_RD1:   act = rd1;
          default: act = {31'd0, irq1};
        endcase
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h required %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input logic [1:0] a, input logic [31:0] exp, input string name);
    chk_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    address = a;
    sb.push_back(e);
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write      = 1'b1;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write = 1'b0;
    writedata = '0; in_port = 4'hF;
    tick(); tick();
    chk(K_RD0, 2'd0, 32'h0, "reset_rd0");
    chk(K_IRQ0, 2'd0, 32'h0, "reset_irq0");
    chk(K_RD1, 2'd0, 32'h0, "reset_rd1");

    reset = 1'b0;
    repeat (W) tick();
    chk(K_RD0, 2'd0, 32'h0000000F, "data_after_reset");
    chk(K_RD0, 2'd1, 32'h0, "reserved_reads_zero");
    chk(K_RD0, 2'd3, 32'hF, "rise_cap_all");
    chk(K_RD1, 2'd3, 32'hF, "any_cap_all");
    wr(2'd3, 32'hF);
    chk(K_RD0, 2'd3, 32'h0, "w1c_all_rise");
    chk(K_RD1, 2'd3, 32'h0, "w1c_all_any");

    in_port = 4'h0;
    repeat (W) tick();
    chk(K_RD0, 2'd0, 32'h0, "data_all_low");
    chk(K_RD0, 2'd3, 32'h0, "rise_ignores_fall");
    chk(K_RD1, 2'd3, 32'hF, "any_sees_fall");
    chk(K_IRQ1, 2'd0, 32'h0, "irq_mask_zero");
    wr(2'd3, 32'hF);

`ifdef QSYS_PIO_DEBOUNCE_EN
    in_port = 4'h1;
    repeat (10) tick();
    in_port = 4'h0;
    repeat (W) tick();
    chk(K_RD0, 2'd0, 32'h0, "glitch_data");
    chk(K_RD0, 2'd3, 32'h0, "glitch_cap_rise");
    chk(K_RD1, 2'd3, 32'h0, "glitch_cap_any");
`else
    in_port = 4'h1;
    tick();
    in_port = 4'h0;
    chk(K_RD0, 2'd0, 32'h0, "pulse_before");
    chk(K_RD0, 2'd0, 32'h1, "pulse_window");
    chk(K_RD0, 2'd0, 32'h0, "pulse_after");
    repeat (3) tick();
    chk(K_RD0, 2'd3, 32'h1, "pulse_cap_rise");
    chk(K_RD1, 2'd3, 32'h1, "pulse_cap_any");
    wr(2'd3, 32'h1);
`endif

    wr(2'd2, 32'h2);
    in_port = 4'h2;
    repeat (D + 1) tick();
    chk(K_IRQ0, 2'd0, 32'h0, "irq_one_before");
    chk(K_IRQ0, 2'd0, 32'h1, "irq_on_time");
    chk(K_IRQ1, 2'd0, 32'h1, "irq_any_on");
    chk(K_RD0, 2'd3, 32'h2, "rise_cap_bit1");
    wr(2'd3, 32'h2);
    chk(K_IRQ0, 2'd0, 32'h0, "irq_cleared");
    chk(K_IRQ1, 2'd0, 32'h0, "irq_any_cleared");

    in_port = 4'h6;
    repeat (D + 2) tick();
    wr(2'd3, 32'h4);
    chk(K_RD0, 2'd3, 32'h4, "collision_set_wins_rise");
    chk(K_RD1, 2'd3, 32'h4, "collision_set_wins_any");
    chk(K_IRQ0, 2'd0, 32'h0, "masked_bit2_no_irq");
    wr(2'd3, 32'h4);
    chk(K_RD0, 2'd3, 32'h0, "bit2_cleared");

    in_port = 4'hE;
    repeat (W) tick();
    chk(K_RD1, 2'd3, 32'h8, "any_rise_bit3");
    chk(K_RD0, 2'd3, 32'h8, "rise_bit3");
    chk(K_IRQ0, 2'd0, 32'h0, "masked_bit3_no_irq");
    wr(2'd3, 32'h8);
    in_port = 4'h6;
    repeat (W) tick();
    chk(K_RD1, 2'd3, 32'h8, "any_fall_bit3");
    chk(K_RD0, 2'd3, 32'h0, "rise_no_fall_bit3");
    chk(K_IRQ1, 2'd0, 32'h0, "any_masked_fall");
    wr(2'd3, 32'h8);
    in_port = 4'hE;
    repeat (W) tick();
    chk(K_RD1, 2'd3, 32'h8, "any_rise_again_bit3");
    chk(K_IRQ0, 2'd0, 32'h0, "masked_again_no_irq");
    wr(2'd2, 32'h8);
    chk(K_IRQ0, 2'd0, 32'h1, "unmask_bit3_irq");
    chk(K_RD0, 2'd2, 32'h8, "mask_readback");
    chk(K_RD0, 2'd0, 32'hE, "data_e");
    wr(2'd0, 32'h0);
    wr(2'd1, 32'hFFFF_FFFF);
    chk(K_RD0, 2'd0, 32'hE, "data_write_ignored");
    chk(K_RD0, 2'd1, 32'h0, "reserved_write_ignored");
    wr(2'd3, 32'hF);
    chk(K_IRQ0, 2'd0, 32'h0, "final_irq_clear");

    tick(); tick();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
